// File: rtl/jtag_cmd_bridge.sv
// Turns JTAG update-stage commands into one request/acknowledge bus transaction each.
// Toggle handshake both ways; a toggle arriving while busy is dropped and flagged as overrun.
module jtag_cmd_bridge #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               upd_toggle_async,
   input  logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] cmd_word,
   output logic                               bus_req,
   output logic                               bus_we,
   output logic [ADDR_WIDTH-1:0]              bus_addr,
   output logic [DATA_WIDTH-1:0]              bus_wdata,
   input  logic                               bus_ack,
   input  logic [DATA_WIDTH-1:0]              bus_rdata,
   output logic [DATA_WIDTH-1:0]              resp_data,
   output logic                               resp_toggle,
   output logic [15:0]                        status
);
   localparam int CMD_W = 2 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;
   localparam logic [1:0] OP_STATUS = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, BUS = 2'd2, RESP = 2'd3} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  s1, s2, s3;
   logic                  upd_edge;
   logic [CMD_W-1:0]      cmd_reg;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] wdata;
   logic [CW-1:0]         wait_cnt;
   logic                  wait_done;
   logic [DATA_WIDTH-1:0] resp_hold;
   logic [7:0]            cmd_count;
   logic                  overrun;
   logic                  timeout_err;
   logic                  busy;
   logic                  status_cmd_done;

   assign upd_edge        = s2 ^ s3;
   assign op              = cmd_reg[CMD_W-1 -: 2];
   assign wdata           = cmd_reg[DATA_WIDTH-1:0];
   assign bus_addr        = cmd_reg[DATA_WIDTH +: ADDR_WIDTH];
   assign bus_wdata       = wdata;
   assign wait_done       = (wait_cnt == WAIT_MAX);
   assign status          = {cmd_count, 5'b0, busy, overrun, timeout_err};
   assign status_cmd_done = (state == RESP) && (op == OP_STATUS);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (upd_edge) state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_NOP:   state_nxt = IDLE;
               OP_WRITE,
               OP_READ:  state_nxt = BUS;
               default:  state_nxt = RESP;
            endcase
         end
         // Ack takes priority over an expiring wait counter.
         BUS:    if (bus_ack || wait_done) state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_req = (state == BUS);
      bus_we  = (state == BUS) && (op == OP_WRITE);
      busy    = (state != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         cmd_reg     <= '0;
         wait_cnt    <= '0;
         resp_hold   <= '0;
         resp_data   <= '0;
         resp_toggle <= 1'b0;
         cmd_count   <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         s1 <= upd_toggle_async;
         s2 <= s1;
         s3 <= s2;

         if (state == IDLE && upd_edge) cmd_reg <= cmd_word;

         if (state == BUS && !bus_ack) wait_cnt <= wait_cnt + CW'(1);
         else                          wait_cnt <= '0;

         case (state)
            DECODE: if (op == OP_STATUS) resp_hold <= DATA_WIDTH'({16'h0, status});
            BUS: begin
               if (bus_ack)        resp_hold <= (op == OP_READ) ? bus_rdata : wdata;
               else if (wait_done) resp_hold <= '1;
            end
            default: ;
         endcase

         if (state == BUS && !bus_ack && wait_done) timeout_err <= 1'b1;
         else if (status_cmd_done)                  timeout_err <= 1'b0;

         // A fresh overrun in the reporting cycle survives the clear.
         if (upd_edge && busy)     overrun <= 1'b1;
         else if (status_cmd_done) overrun <= 1'b0;

         if (state == RESP) begin
            resp_data   <= resp_hold;
            resp_toggle <= ~resp_toggle;
            cmd_count   <= cmd_count + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_jtag_cmd_bridge.sv
// Randomised and directed bench for jtag_cmd_bridge against a command-level reference model.
module tb_jtag_cmd_bridge;
   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        upd_toggle_async;
   logic [41:0] cmd_word;
   logic        bus_req, bus_we, bus_ack;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata, resp_data;
   logic        resp_toggle;
   logic [15:0] status;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_count;
   logic       m_tog, m_ovr, m_to;

   int          obs_req_cycles, obs_first, obs_last, obs_resp, obs_ntog;
   logic        obs_we, obs_stable, noise;
   logic [7:0]  obs_addr;
   logic [31:0] obs_wdata;

   jtag_cmd_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .upd_toggle_async(upd_toggle_async), .cmd_word(cmd_word),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .resp_data(resp_data),
      .resp_toggle(resp_toggle), .status(status)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] model_resp(input logic [1:0] op, input logic [31:0] wd,
                                              input logic [31:0] rd, input int dly);
      if (op == 2'b11) return {16'h0, m_count, 5'b0, 1'b1, m_ovr, m_to};
      if (dly > TMO) return 32'hFFFF_FFFF;
      return (op == 2'b10) ? rd : wd;
   endfunction

   function automatic int model_req_cycles(input logic [1:0] op, input int dly);
      if (op != 2'b01 && op != 2'b10) return 0;
      return (dly > TMO) ? TMO + 1 : dly + 1;
   endfunction

   function automatic void model_update(input logic [1:0] op, input int dly);
      if (op == 2'b00) return;
      if (op != 2'b11 && dly > TMO) m_to = 1'b1;
      if (op == 2'b11) begin
         m_ovr = 1'b0;
         m_to  = 1'b0;
      end
      m_count = m_count + 8'd1;
      m_tog   = ~m_tog;
   endfunction

   function automatic logic [15:0] model_status();
      return {m_count, 5'b0, 1'b0, m_ovr, m_to};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      upd_toggle_async = 1'b0;
      cmd_word = '0;
      bus_ack = 1'b0;
      bus_rdata = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      m_count = 8'd0;
      m_tog = 1'b0;
      m_ovr = 1'b0;
      m_to = 1'b0;
   endtask

   // Issues one command and plays the bus slave for a fixed window, recording what it saw.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] ad, input logic [31:0] wd,
                          input int ack_dly, input logic [31:0] rd, input int retog);
      logic prev;
      obs_req_cycles = 0; obs_first = -1; obs_last = -1; obs_resp = -1; obs_ntog = 0;
      obs_stable = 1'b1; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
      @(negedge clock);
      cmd_word = {op, ad, wd};
      upd_toggle_async = ~upd_toggle_async;
      prev = resp_toggle;
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         bus_ack = 1'b0;
         if (c == retog) begin
            cmd_word = {2'b01, ~ad, ~wd};
            upd_toggle_async = ~upd_toggle_async;
         end
         if (bus_req) begin
            if (obs_first < 0) begin
               obs_first = c; obs_we = bus_we; obs_addr = bus_addr; obs_wdata = bus_wdata;
            end else if (bus_we !== obs_we || bus_addr !== obs_addr || bus_wdata !== obs_wdata) begin
               obs_stable = 1'b0;
            end
            if (obs_req_cycles == ack_dly) begin
               bus_ack = 1'b1;
               bus_rdata = rd;
            end else begin
               bus_rdata = $urandom;
            end
            obs_req_cycles++;
            obs_last = c;
         end else if (noise) begin
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
         end
         if (resp_toggle !== prev) begin
            obs_ntog++;
            if (obs_resp < 0) obs_resp = c;
            prev = resp_toggle;
         end
      end
      bus_ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clock);
      n_checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata} !== 42'h0) begin
         n_errors++; $display("FAIL reset_bus got %b/%b/%h/%h want all zero", bus_req, bus_we, bus_addr, bus_wdata);
      end
      n_checks++;
      if (resp_data !== 32'h0 || resp_toggle !== 1'b0) begin
         n_errors++; $display("FAIL reset_resp got %h/%b want 0/0", resp_data, resp_toggle);
      end
      n_checks++;
      if (status !== 16'h0000) begin
         n_errors++; $display("FAIL reset_status got %h want 0000", status);
      end
   endtask

   task automatic test_write();
      run_cmd(2'b01, 8'h12, 32'hA5A5_0001, 3, 32'h0, -1);
      model_update(2'b01, 3);
      n_checks++;
      if (obs_first !== 3) begin
         n_errors++; $display("FAIL wr_req_latency got %0d want 3", obs_first);
      end
      n_checks++;
      if (obs_req_cycles !== 4) begin
         n_errors++; $display("FAIL wr_req_cycles got %0d want 4", obs_req_cycles);
      end
      n_checks++;
      if (obs_we !== 1'b1 || obs_addr !== 8'h12 || obs_wdata !== 32'hA5A5_0001 || !obs_stable) begin
         n_errors++; $display("FAIL wr_bus got we=%b addr=%h wd=%h stable=%b want 1/12/a5a50001/1",
                              obs_we, obs_addr, obs_wdata, obs_stable);
      end
      n_checks++;
      if (resp_data !== 32'hA5A5_0001 || resp_toggle !== 1'b1 || obs_ntog !== 1) begin
         n_errors++; $display("FAIL wr_resp got %h tog=%b n=%0d want a5a50001/1/1", resp_data, resp_toggle, obs_ntog);
      end
      n_checks++;
      if (obs_resp !== obs_last + 2) begin
         n_errors++; $display("FAIL wr_resp_latency got %0d want %0d", obs_resp, obs_last + 2);
      end
      n_checks++;
      if (status !== 16'h0100) begin
         n_errors++; $display("FAIL wr_status got %h want 0100", status);
      end
   endtask

   task automatic test_read();
      int dly;
      dly = $urandom_range(0, 3);
      run_cmd(2'b10, 8'h34, 32'h1111_2222, dly, 32'hCAFE_F00D, -1);
      model_update(2'b10, dly);
      n_checks++;
      if (obs_we !== 1'b0 || obs_addr !== 8'h34 || obs_first !== 3 || obs_last !== 3 + dly) begin
         n_errors++; $display("FAIL rd_bus got we=%b addr=%h req %0d..%0d want 0/34 req 3..%0d",
                              obs_we, obs_addr, obs_first, obs_last, 3 + dly);
      end
      n_checks++;
      if (resp_data !== 32'hCAFE_F00D || resp_toggle !== m_tog) begin
         n_errors++; $display("FAIL rd_resp got %h/%b want cafef00d/%b", resp_data, resp_toggle, m_tog);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] exp;
      run_cmd(2'b10, 8'h56, 32'h0, 99, 32'h0, -1);
      model_update(2'b10, 99);
      n_checks++;
      if (obs_req_cycles !== TMO + 1) begin
         n_errors++; $display("FAIL to_req_cycles got %0d want %0d", obs_req_cycles, TMO + 1);
      end
      n_checks++;
      if (resp_data !== 32'hFFFF_FFFF || status[0] !== 1'b1 || status !== model_status()) begin
         n_errors++; $display("FAIL to_resp got %h status %h want ffffffff status %h", resp_data, status, model_status());
      end
      for (int k = 0; k < 2; k++) begin
         exp = model_resp(2'b11, 32'h0, 32'h0, 0);
         run_cmd(2'b11, 8'h0, 32'h0, 0, 32'h0, -1);
         model_update(2'b11, 0);
         n_checks++;
         if (resp_data !== exp || resp_data[0] !== (k == 0)) begin
            n_errors++; $display("FAIL to_status%0d got %h want %h", k, resp_data, exp);
         end
         n_checks++;
         if (obs_resp !== 4 || status[0] !== 1'b0) begin
            n_errors++; $display("FAIL to_status_clear%0d got lat %0d status %h want lat 4 bit0 0", k, obs_resp, status);
         end
      end
   endtask

   task automatic test_ack_at_limit();
      run_cmd(2'b01, 8'h77, 32'h0BAD_BEEF, TMO, 32'h0, -1);
      model_update(2'b01, TMO);
      n_checks++;
      if (resp_data !== 32'h0BAD_BEEF || status[0] !== 1'b0 || obs_req_cycles !== TMO + 1) begin
         n_errors++; $display("FAIL ack_limit got %h status %h cycles %0d want 0badbeef bit0 0 cycles %0d",
                              resp_data, status, obs_req_cycles, TMO + 1);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] exp;
      run_cmd(2'b10, 8'h9A, 32'h0, TMO, 32'h1234_5678, 4);
      model_update(2'b10, TMO);
      m_ovr = 1'b1;
      n_checks++;
      if (resp_data !== 32'h1234_5678 || obs_ntog !== 1 || obs_req_cycles !== TMO + 1 || !obs_stable) begin
         n_errors++; $display("FAIL ovr_first got %h n=%0d cycles=%0d stable=%b want 12345678/1/%0d/1",
                              resp_data, obs_ntog, obs_req_cycles, obs_stable, TMO + 1);
      end
      n_checks++;
      if (status !== model_status() || status[1] !== 1'b1) begin
         n_errors++; $display("FAIL ovr_status got %h want %h", status, model_status());
      end
      exp = model_resp(2'b11, 32'h0, 32'h0, 0);
      run_cmd(2'b11, 8'h0, 32'h0, 0, 32'h0, -1);
      model_update(2'b11, 0);
      n_checks++;
      if (resp_data !== exp || status !== model_status()) begin
         n_errors++; $display("FAIL ovr_report got %h status %h want %h status %h", resp_data, status, exp, model_status());
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [7:0]  ad;
      logic [31:0] wd, rd, exp;
      int          dly;
      noise = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         ad = 8'($urandom);
         wd = $urandom;
         rd = $urandom;
         dly = $urandom_range(0, 6);
         exp = model_resp(op, wd, rd, dly);
         run_cmd(op, ad, wd, dly, rd, -1);
         n_checks++;
         if (obs_req_cycles !== model_req_cycles(op, dly)) begin
            n_errors++; $display("FAIL rand_req i=%0d op=%0d got %0d want %0d", i, op, obs_req_cycles, model_req_cycles(op, dly));
         end
         model_update(op, dly);
         n_checks++;
         if (obs_ntog !== ((op != 2'b00) ? 1 : 0) || resp_toggle !== m_tog) begin
            n_errors++; $display("FAIL rand_tog i=%0d op=%0d got n=%0d tog=%b want tog %b", i, op, obs_ntog, resp_toggle, m_tog);
         end
         if (op != 2'b00) begin
            n_checks++;
            if (resp_data !== exp) begin
               n_errors++; $display("FAIL rand_resp i=%0d op=%0d got %h want %h", i, op, resp_data, exp);
            end
         end
         if (op == 2'b01 || op == 2'b10) begin
            n_checks++;
            if (obs_we !== (op == 2'b01) || obs_addr !== ad || (op == 2'b01 && obs_wdata !== wd) || !obs_stable) begin
               n_errors++; $display("FAIL rand_bus i=%0d got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                                    i, obs_we, obs_addr, obs_wdata, op == 2'b01, ad, wd);
            end
         end
         n_checks++;
         if (status !== model_status()) begin
            n_errors++; $display("FAIL rand_status i=%0d got %h want %h", i, status, model_status());
         end
      end
      noise = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(negedge clock);
      cmd_word = {2'b10, 8'h55, 32'h0};
      upd_toggle_async = ~upd_toggle_async;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clock);
         if (bus_req) seen = 1;
      end
      n_checks++;
      if (seen == 0) begin
         n_errors++; $display("FAIL mid_req got no bus_req want bus_req");
      end
      reset = 1'b1;
      upd_toggle_async = 1'b0;
      @(negedge clock);
      n_checks++;
      if (bus_req !== 1'b0 || resp_toggle !== 1'b0 || status !== 16'h0) begin
         n_errors++; $display("FAIL mid_reset got req=%b tog=%b status=%h want 0/0/0000", bus_req, resp_toggle, status);
      end
      reset = 1'b0;
      m_count = 8'd0; m_tog = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clock);
         if (bus_req || resp_toggle) seen = 1;
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++; $display("FAIL mid_quiet got activity after reset want none");
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp;
      int          nop_tog;
      nop_tog = 0;
      do_reset();
      for (int i = 0; i < 255; i++) begin
         if (i % 32 == 0) begin
            run_cmd(2'b00, 8'($urandom), $urandom, 0, 32'h0, -1);
            nop_tog += obs_ntog;
         end
         run_cmd(2'b01, 8'(i), $urandom, 0, 32'h0, -1);
         model_update(2'b01, 0);
      end
      n_checks++;
      if (nop_tog != 0 || status !== 16'hFF00 || status !== model_status()) begin
         n_errors++; $display("FAIL wrap_pre got nop toggles %0d status %h want 0 and ff00", nop_tog, status);
      end
      exp = model_resp(2'b11, 32'h0, 32'h0, 0);
      run_cmd(2'b11, 8'h0, 32'h0, 0, 32'h0, -1);
      model_update(2'b11, 0);
      n_checks++;
      if (resp_data !== exp || resp_data[15:8] !== 8'hFF) begin
         n_errors++; $display("FAIL wrap_report got %h want %h", resp_data, exp);
      end
      n_checks++;
      if (status[15:8] !== 8'h00 || resp_toggle !== m_tog || m_tog !== 1'b0) begin
         n_errors++; $display("FAIL wrap_count got status %h tog %b want count 00 tog 0", status, resp_toggle);
      end
   endtask

   initial begin
      reset = 1'b1;
      upd_toggle_async = 1'b0;
      cmd_word = '0;
      bus_ack = 1'b0;
      bus_rdata = '0;
      noise = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_ack_at_limit();
      test_overrun();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no completion want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/jtag_cmd_bridge.md
Name: jtag_cmd_bridge

Overview:
- System-clock-domain stage directly downstream of the JTAG user-DR core.
- Takes the command word that the core's update stage presents, plus a toggle that flips on every JUPDATE.
- Synchronises the toggle, decodes the command, and runs a single transaction on a simple request/acknowledge register bus.
- Returns a response word and a response toggle that the JTAG core captures on its next DR scan.

Parameters:
ADDR_WIDTH, 8, bus address width
DATA_WIDTH, 32, bus data and response width
TIMEOUT, 255, maximum cycles bus_req may wait for bus_ack before the transaction aborts

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
upd_toggle_async  in  1  flips once per JTAG update; asynchronous to clock
cmd_word  in  2+ADDR_WIDTH+DATA_WIDTH  {opcode[1:0], addr, wdata}; held stable by the JTAG side from the toggle until the next toggle
bus_req  out  1  transaction request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  ADDR_WIDTH  transaction address
bus_wdata  out  DATA_WIDTH  write data
bus_ack  in  1  single-cycle completion strobe
bus_rdata  in  DATA_WIDTH  read data, valid while bus_ack=1
resp_data  out  DATA_WIDTH  last response word
resp_toggle  out  1  flips once per completed command
status  out  16  {cmd_count[7:0], 5'b0, busy, overrun, timeout_err}

Behaviour:
- Reset values: all outputs, the sync flops, cmd_count and the FSM are cleared (FSM goes to IDLE). Reset mid-transaction drops bus_req in the next cycle with no response. The JTAG side re-arms by toggling again.
- Synchroniser:
  - upd_toggle_async passes through 3 flops s1, s2, s3.
  - upd_edge = s2 ^ s3, one cycle wide per toggle.
- FSM: IDLE, DECODE, BUS, RESP.
  - IDLE, on upd_edge: latch cmd_word into cmd_reg and go to DECODE.
  - DECODE, by opcode:
    - 00 NOP: go to IDLE. No response, count unchanged.
    - 01 WRITE: go to BUS with bus_we=1 and bus_wdata=wdata.
    - 10 READ: go to BUS with bus_we=0.
    - 11 STATUS: go to RESP with response = {16'b0, status}, zero-extended or truncated to DATA_WIDTH.
  - BUS:
    - bus_req=1, with bus_addr/bus_we/bus_wdata stable, until bus_ack is sampled high.
    - On ack, go to RESP. The response is bus_rdata for READ and the written wdata echo for WRITE.
    - bus_req deasserts in the cycle after ack.
  - BUS timeout:
    - A wait counter starts at 0 on entry and increments each cycle without ack.
    - When it reaches TIMEOUT, drop bus_req, set timeout_err (sticky) and go to RESP with response = all-ones.
    - If ack arrives in the same cycle the counter hits TIMEOUT, ack wins.
  - RESP: load resp_data, flip resp_toggle, increment cmd_count (mod 256, 255 wraps to 0), then go to IDLE.
- Latency: upd_edge at cycle E gives DECODE at E+1 and bus_req high at E+2. An ack at cycle A gives RESP at A+1, with resp_data/resp_toggle updated at A+2.
- busy = (state != IDLE).
- Overrun:
  - An upd_edge while not IDLE sets overrun (sticky).
  - The new command is discarded and the current transaction is unaffected.
- Sticky flags clear only on reset, or when a STATUS command executes (cleared in RESP after being reported).
- Bus rule: only one outstanding transaction at a time. bus_ack while bus_req=0 is ignored.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, status=16'h0000, busy=0.
- Toggle with WRITE, addr=8'h12, wdata=32'hA5A5_0001; ack 3 cycles after req → exactly one write on the bus; resp_data=32'hA5A5_0001, resp_toggle=1, cmd_count=1.
- Toggle with READ, addr=8'h34; ack with bus_rdata=32'hCAFE_F00D → bus_we=0, resp_data=32'hCAFE_F00D, resp_toggle flips, bus_req high from E+2 through the ack cycle.
- READ with bus_ack never asserted, TIMEOUT=4 → bus_req high exactly 5 cycles; resp_data=32'hFFFF_FFFF; timeout_err=1. A following STATUS returns status bit0=1 and clears it. A second STATUS returns bit0=0.
- Second toggle while BUS is waiting on ack → overrun=1; the first command completes; cmd_count increments by 1 only.
- 256 NOP/WRITE mix: 255 WRITEs then a STATUS → cmd_count wraps to 0 after the 256th counted command. NOPs leave resp_toggle and cmd_count unchanged.
